// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_e;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sext;
      logic        wren;
   } lsu_req_t;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: winner selection; fixed priority with a starvation override,
// or round robin when DMEM_ARB_RR_EN is defined.
module dmem_arb_pick #(
   parameter int MAX_WAIT = 8
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_p0_req,
   input  logic i_p1_req,
   input  logic i_opp,
   output logic o_p0_gnt,
   output logic o_p1_gnt
);
   logic p1_wins;
`ifdef DMEM_ARB_RR_EN
   logic last_q, last_d;
   assign p1_wins = i_p1_req & (~i_p0_req | ~last_q);
   always_comb last_d = o_p1_gnt ? 1'b1 : o_p0_gnt ? 1'b0 : last_q;
   always_ff @(posedge i_clk) last_q <= i_reset ? 1'b1 : last_d;
`else
   logic [7:0] wait_cnt_q, wait_cnt_d;
   assign p1_wins = i_p1_req & (~i_p0_req | (wait_cnt_q == 8'(MAX_WAIT)));
   // counts only lost opportunities; any idle gap on port 1 restarts the count
   always_comb wait_cnt_d = (~i_p1_req | o_p1_gnt) ? 8'd0 : i_opp ? wait_cnt_q + 8'd1 : wait_cnt_q;
   always_ff @(posedge i_clk) wait_cnt_q <= i_reset ? 8'd0 : wait_cnt_d;
`endif
   assign o_p1_gnt = i_opp & p1_wins;
   assign o_p0_gnt = i_opp & i_p0_req & ~p1_wins;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one LSU access path between the core (port 0) and a DMA/debug
// master (port 1); DMEM_ARB_RR_EN selects round robin instead of fixed priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_p0_req,
   input  logic [31:0] i_p0_addr,
   input  logic [31:0] i_p0_wdata,
   input  logic [1:0]  i_p0_size,
   input  logic        i_p0_signed,
   input  logic        i_p0_wren,
   input  logic        i_p1_req,
   input  logic [31:0] i_p1_addr,
   input  logic [31:0] i_p1_wdata,
   input  logic [1:0]  i_p1_size,
   input  logic        i_p1_signed,
   input  logic        i_p1_wren,
   output logic        o_p0_gnt,
   output logic        o_p1_gnt,
   output logic        o_p0_rvalid,
   output logic        o_p1_rvalid,
   output logic [31:0] o_p0_rdata,
   output logic [31:0] o_p1_rdata,
   output logic [31:0] o_lsu_addr,
   output logic [31:0] o_lsu_st_data,
   output logic [1:0]  o_lsu_size,
   output logic        o_lsu_signed,
   output logic        o_lsu_wren,
   input  logic [31:0] i_lsu_ld_data
);
   arb_state_e  state_q, state_d;
   lsu_req_t    req_q, req_d;
   logic        owner_q;
   logic [31:0] p0_rdata_q, p1_rdata_q;
   logic        opp;
   // grants are suppressed during reset so nothing is accepted into a discarded access
   assign opp = ~i_reset & (state_q != ACCESS);
   dmem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_p0_req (i_p0_req),
      .i_p1_req (i_p1_req),
      .i_opp    (opp),
      .o_p0_gnt (o_p0_gnt),
      .o_p1_gnt (o_p1_gnt)
   );
   always_ff @(posedge i_clk) state_q <= i_reset ? IDLE : state_d;
   always_comb state_d = (state_q == ACCESS) ? RESP : (i_p0_req | i_p1_req) ? ACCESS : IDLE;
   always_comb begin
      o_lsu_wren  = (state_q == ACCESS) & req_q.wren;
      o_p0_rvalid = (state_q == RESP) & ~owner_q;
      o_p1_rvalid = (state_q == RESP) & owner_q;
   end
   always_comb req_d = o_p1_gnt ? lsu_req_t'{i_p1_addr, i_p1_wdata, i_p1_size, i_p1_signed, i_p1_wren}
                                : lsu_req_t'{i_p0_addr, i_p0_wdata, i_p0_size, i_p0_signed, i_p0_wren};
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         req_q      <= '0;
         owner_q    <= 1'b0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
      end else begin
         if (o_p0_gnt | o_p1_gnt) begin
            req_q   <= req_d;
            owner_q <= o_p1_gnt;
         end
         if (state_q == ACCESS && !owner_q) p0_rdata_q <= req_q.wren ? 32'd0 : i_lsu_ld_data;
         if (state_q == ACCESS && owner_q) p1_rdata_q <= req_q.wren ? 32'd0 : i_lsu_ld_data;
      end
   end
   assign o_lsu_addr    = req_q.addr;
   assign o_lsu_st_data = req_q.wdata;
   assign o_lsu_size    = req_q.size;
   assign o_lsu_signed  = req_q.sext;
   assign o_p0_rdata    = p0_rdata_q;
   assign o_p1_rdata    = p1_rdata_q;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer that shares the single data-memory/LSU access path between the core load/store stage (port 0) and a DMA/debug master (port 1). It grants one requester at a time, registers the winning request, drives the LSU for exactly one access cycle, and returns the load data with a one-cycle valid pulse to the winner. It sits between the requesters and the `lsu` instance and adds no address decoding of its own.

## Interface
- `MAX_WAIT`, default 8: consecutive lost grant opportunities that force a port-1 grant in fixed-priority mode, range 1..255.
- `i_clk` in 1: clock, rising edge.
- `i_reset` in 1: synchronous reset, active high.
- `i_p0_req` / `i_p1_req` in 1: request, held until granted.
- `i_pN_addr` in 32: byte address.
- `i_pN_wdata` in 32: store data.
- `i_pN_size` in 2: 00 byte, 01 half, 10 word.
- `i_pN_signed` in 1: sign-extend load.
- `i_pN_wren` in 1: 1 store, 0 load.
- `o_p0_gnt` / `o_p1_gnt` out 1: combinational grant; request accepted on the edge where `req & gnt` is true.
- `o_pN_rvalid` out 1: one-cycle completion pulse for loads and stores.
- `o_pN_rdata` out 32: load data, valid with `rvalid`; 0 for stores.
- `o_lsu_addr`, `o_lsu_st_data` out 32: to LSU.
- `o_lsu_size` out 2, `o_lsu_signed` out 1, `o_lsu_wren` out 1: to LSU.
- `i_lsu_ld_data` in 32: LSU load data, combinational within the access cycle.

## Operation
- FSM states are IDLE, ACCESS and RESP. Reset state is IDLE.
- **Grant opportunity**
  - Occurs in IDLE and RESP only. Grants are zero in ACCESS.
  - At most one grant is high per cycle.
  - A grant is never asserted to a port whose `req` is low.
- **IDLE / RESP transitions**
  - If any request is present, the winner's fields are captured into the request register and the FSM goes to ACCESS.
  - Otherwise RESP returns to IDLE, and IDLE stays in IDLE.
- **ACCESS**
  - `o_lsu_*` is driven from the request register.
  - `o_lsu_wren` equals the captured wren.
  - On the edge, `i_lsu_ld_data` (loads) or 0 (stores) is latched into the winner's `o_pN_rdata`, and the FSM goes to RESP.
- **RESP**: the winner's `o_pN_rvalid` is 1 for this cycle only. `o_pN_rdata` holds its value until that port's next completion.
- **LSU outputs outside ACCESS**: `o_lsu_wren` is 0. Address, data, size and signed hold the last captured values.
- **Fixed priority** (macro absent)
  - Port 0 wins by default.
  - An 8-bit `wait_cnt` increments at each opportunity where port 1 requests and loses.
  - `wait_cnt` clears when port 1 is granted, or when port 1 is not requesting.
  - When `wait_cnt == MAX_WAIT`, port 1 wins the next opportunity where it requests.
- **Round robin** (macro present)
  - `last` records the most recent winner and resets to 1, so port 0 wins the first contention.
  - On contention the non-`last` port wins.
  - A lone requester always wins.
- Simultaneous events:
  - A new grant in RESP coincides with the previous `rvalid` pulse. This is legal.
  - A requester may drop `req` only after it is granted.
- **Reset in any state**
  - FSM goes to IDLE.
  - Reset values: grants 0, all `rvalid` 0, all `rdata` 0, all `o_lsu_*` 0, `wait_cnt` 0.
  - An in-flight access produces no `rvalid`.

## Timing
- **Request to access**: a request granted in cycle N is driven to the LSU in cycle N+1 (`o_lsu_wren` high for stores).
- **Completion**: `rvalid` and `rdata` are valid in cycle N+2.
- **Throughput**: one access per 2 cycles when back-to-back; 3 cycles from IDLE with gaps.
- **Write timing**: stores are written by the LSU on the ACCESS-cycle rising edge (end of N+1).
- **Grant path**: grant is combinational from `req`, state, `last` and `wait_cnt`. There is no path from `i_lsu_ld_data` to grant.

## Configuration
- The macro is `DMEM_ARB_RR_EN`.
  - Defined: round-robin arbitration; `wait_cnt` and `MAX_WAIT` are unused and removed.
  - Undefined: fixed priority for port 0 with the `MAX_WAIT` starvation override.
- Port list is identical in both builds.

## Structure
- Package `dmem_arb_pkg`:
  - `lsu_req_t` struct (addr, wdata, size, signed, wren).
  - State enum `arb_state_e` (IDLE, ACCESS, RESP).
  - Size constants `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
- Sub-module `dmem_arb_pick`:
  - Pure winner selection plus the `last` / `wait_cnt` registers.
  - Inputs: both `req` signals and the opportunity flag. Outputs: the two grants.
  - The top level holds the FSM, request register and response registers.

## Test plan
- **Single load**: p0 loads addr 0x0000_0010 with size 10 while the LSU returns 0xDEAD_BEEF. Required: `o_p0_gnt` in cycle 0, `o_lsu_addr` = 0x10 with `wren` 0 in cycle 1, `o_p0_rvalid` = 1 with rdata 0xDEAD_BEEF in cycle 2.
- **Back-to-back**: p0 stores 0x1234_5678 to 0x20, then loads 0x20. Required: second grant in the RESP cycle of the first; `o_lsu_wren` high exactly one cycle; second `rvalid` 2 cycles after the first; rdata 0 for the store.
- **Fixed priority starvation**: with `MAX_WAIT` = 3, both ports request continuously. Required: p0 wins 3 opportunities, p1 wins the 4th, then the pattern repeats.
- **Round robin**: build with `DMEM_ARB_RR_EN` and both ports requesting continuously. Required: grants alternate p0, p1, p0, p1.
- **Reset mid-access**: assert `i_reset` in the ACCESS cycle of a p1 store. Required: the next cycle shows IDLE, no `rvalid`, `o_lsu_wren` 0 and all outputs 0.
- **Lone requester**: only p1 requests, in fixed mode. Required: p1 is granted immediately and `wait_cnt` stays 0.
